decoder_rr_arbiter: RTL and testbench

- Four-requester round-robin arbiter that shares one resource, selected through a 2-to-4 decoder, between four clients.
- Picks a winner and holds the grant while the winner keeps requesting.
- Enforces a maximum hold time, then drives the winning index through a 2-to-4 one-hot decode stage to produce per-client grant lines.
- Sits between client request lines and the shared resource's select inputs.

---
 rtl/arb_pkg.sv | 28 ++
 rtl/grant_decoder_2to4.sv | 15 +
 rtl/decoder_rr_arbiter.sv | 108 ++++++++++
 tb/tb_decoder_rr_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the four-client round-robin arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First set bit of req when scanning start, start+1, ... (mod 4).
  // Returns start when req is empty; callers only use it with req != 0.
  function automatic logic [1:0] next_winner(input logic [NUM_REQ-1:0] req,
                                             input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    next_winner = start;
    found       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = start + 2'(i);
      if (!found && req[idx]) begin
        next_winner = idx;
        found       = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/grant_decoder_2to4.sv
// 2-to-4 one-hot decode of the winning index, gated by the grant-valid flag.
module grant_decoder_2to4
  import arb_pkg::*;
(
  input  logic [1:0]         idx,
  input  logic               valid,
  output logic [NUM_REQ-1:0] onehot
);

  // One grant line per client; at most one can match idx.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_line
    assign onehot[gi] = valid && (idx == 2'(gi));
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Four-client round-robin arbiter with a bounded hold time. The winner index
// and grant-valid flag are registered; per-client grant lines are decoded
// from them, so no input reaches an output combinationally.
module decoder_rr_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_e         state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               timeout_q, timeout_d;
  logic [NUM_REQ-1:0] others;
  logic [1:0]         after_w;

  // Requests from everyone except the current holder, and the slot after it.
  assign others  = req & ~(4'b0001 << idx_q);
  assign after_w = idx_q + 2'd1;

  // Next-state arbitration: release, hold-limit revoke, saturate or count.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && (req != '0)) begin
          state_d = GRANT;
          idx_d   = next_winner(req, ptr_q);
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          // Holder released: hand off directly if someone else is waiting.
          ptr_d  = after_w;
          hold_d = '0;
          if (en && (req != '0)) begin
            idx_d = next_winner(req, after_w);
          end else begin
            state_d = IDLE;
            idx_d   = 2'd0;
          end
        end else if (hold_q == HOLD_LAST) begin
          // Hold limit reached: revoke only if enabled and someone is waiting;
          // otherwise the counter simply stays at its last value.
          if (en && (others != '0)) begin
            idx_d     = next_winner(others, after_w);
            ptr_d     = after_w;
            hold_d    = '0;
            timeout_d = 1'b1;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
        hold_d  = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      ptr_q     <= 2'd0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_valid = (state_q == GRANT);
  assign gnt_idx   = idx_q;
  assign timeout   = timeout_q;

  grant_decoder_2to4 u_dec (
    .idx    (idx_q),
    .valid  (gnt_valid),
    .onehot (gnt)
  );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_decoder_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int vectors;
  int miscompares;
  bit check_on;

  // Model state: owner = -1 when no grant; held = cycles the owner has shown.
  int m_owner;
  int m_held;
  int m_ptr;
  bit m_timeout;

  decoder_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_req(input logic [3:0] r, input int start);
    for (int i = 0; i < 4; i++) begin
      if (r[(start + i) % 4]) return (start + i) % 4;
    end
    return -1;
  endfunction

  // Behavioural model, advanced on each rising edge from the applied inputs.
  always @(posedge clk) begin
    logic [3:0] rest;
    if (!reset) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_timeout = 0;
    end else begin
      m_timeout = 0;
      if (m_owner < 0) begin
        if (en && req != 4'b0) begin
          m_owner = first_req(req, m_ptr);
          m_held  = 1;
        end
      end else if (!req[m_owner]) begin
        m_ptr = (m_owner + 1) % 4;
        if (en && req != 4'b0) begin
          m_owner = first_req(req, m_ptr);
          m_held  = 1;
        end else begin
          m_owner = -1;
          m_held  = 0;
        end
      end else begin
        rest = req;
        rest[m_owner] = 1'b0;
        if (m_held >= MAX_HOLD && en && rest != 4'b0) begin
          m_ptr     = (m_owner + 1) % 4;
          m_owner   = first_req(rest, m_ptr);
          m_held    = 1;
          m_timeout = 1;
        end else begin
          m_held++;
        end
      end
    end
  end

  // Per-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clk) begin
    logic [3:0] e_gnt;
    logic [1:0] e_idx;
    if (check_on) begin
      e_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      e_idx = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
      vectors++;
      if (gnt !== e_gnt || gnt_idx !== e_idx || gnt_valid !== (m_owner >= 0)
          || timeout !== m_timeout || $countones(gnt) > 1) begin
        miscompares++;
        $display("FAIL model t=%0t req=%b en=%b: gnt=%b idx=%0d valid=%b to=%b, required gnt=%b idx=%0d valid=%b to=%b",
                 $time, req, en, gnt, gnt_idx, gnt_valid, timeout,
                 e_gnt, e_idx, (m_owner >= 0), m_timeout);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; check_on = 0;
    m_owner = -1; m_held = 0; m_ptr = 0; m_timeout = 0;
    reset = 1'b0; en = 1'b0; req = 4'b0;
    tick();
    check_on = 1;
    reset = 1'b1; en = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_out", {gnt_valid, timeout, gnt_idx}, 4'b0000);
      chk("idle_gnt", gnt, 4'b0000);
    end

    // Priority from ptr=0, then direct handoff.
    req = 4'b0110; tick();
    chk("first_gnt", gnt, 4'b0010);
    chk("first_idx", {2'b00, gnt_idx}, 4'd1);
    req = 4'b0100; tick();
    chk("handoff_gnt", gnt, 4'b0100);
    chk("handoff_idx", {1'b0, gnt_valid, gnt_idx}, 4'b0110);
    req = 4'b0000; tick();
    chk("release_gnt", gnt, 4'b0000);

    // Full load rotation: 8 cycles each, order 0,1,2,3,0.
    do_reset();
    req = 4'b1111; tick();
    chk("rot_gnt_0", gnt, 4'b0001);
    for (int k = 1; k < 40; k++) begin
      tick();
      chk($sformatf("rot_gnt_%0d", k), gnt, 4'b0001 << ((k / 8) % 4));
      chk($sformatf("rot_to_%0d", k), {3'b0, timeout}, {3'b0, (k % 8) == 0});
    end

    // Lone requester never times out.
    do_reset();
    req = 4'b1000;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("solo_%0d", k), {timeout, gnt[2:0]} | {gnt[3], 3'b0}, 4'b1000);
    end

    // en=0 keeps a grant past the limit; re-enable revokes with timeout.
    do_reset();
    req = 4'b0100; tick();
    chk("hold2_gnt", gnt, 4'b0100);
    en = 1'b0; req = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("en0_%0d", k), {timeout, gnt[2:0]}, 4'b0100);
    end
    en = 1'b1; tick();
    chk("reen_gnt", gnt, 4'b1000);
    chk("reen_to", {3'b0, timeout}, 4'b0001);
    tick();
    chk("reen_to_off", {3'b0, timeout}, 4'b0000);

    // Mid-grant reset clears everything and returns ptr to 0.
    req = 4'b0000; tick();
    req = 4'b0001; tick();
    chk("pre_rst_gnt", gnt, 4'b0001);
    reset = 1'b0; tick();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_out", {gnt_valid, timeout, gnt_idx}, 4'b0000);
    reset = 1'b1; req = 4'b0011; tick();
    chk("post_rst_gnt", gnt, 4'b0001);

    // Randomized traffic; the model checker runs every cycle.
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) == 0) en = ~en;
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      tick();
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
